// File: rtl/dbnc_bank.sv
`default_nettype none
// ============================================================================
// Module      : dbnc_bank
// Description : Multi-channel debounce / edge-detect bank. Each raw async
//               input is passed through a two-flop synchroniser plus a
//               "prev" stage, qualified by a per-channel stability counter,
//               and presented as a clean level with one-cycle rise/fall
//               pulses.
// Optional    : define DBNC_GLITCH_CNT_EN to add per-channel 8-bit
//               saturating glitch counters (aborted pending transitions)
//               together with the glitch_clr / glitch_cnt ports.
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               sig_in     - [NCH] raw asynchronous inputs
//               sig_filt   - [NCH] debounced level
//               sig_rise   - [NCH] one-cycle pulse on accepted 0->1
//               sig_fall   - [NCH] one-cycle pulse on accepted 1->0
//               any_rise   - OR of sig_rise
//               glitch_clr - synchronous clear of glitch counters (option)
//               glitch_cnt - [8*NCH] glitch counts, ch i at [8i+7:8i] (option)
// Revision    : 1.0 - initial release
// ============================================================================
module dbnc_bank #(
   parameter int unsigned    NCH      = 4,
   parameter int unsigned    STBL_CNT = 50000,
   parameter logic [NCH-1:0] INIT     = {NCH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   sig_in,
`ifdef DBNC_GLITCH_CNT_EN
   input  logic             glitch_clr,
   output logic [8*NCH-1:0] glitch_cnt,
`endif
   output logic [NCH-1:0]   sig_filt,
   output logic [NCH-1:0]   sig_rise,
   output logic [NCH-1:0]   sig_fall,
   output logic             any_rise
);

   localparam int unsigned      CNT_W   = $clog2(STBL_CNT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STBL_CNT - 1);

   logic [NCH-1:0]   sync1_q, sync1_d;
   logic [NCH-1:0]   sync2_q, sync2_d;
   logic [NCH-1:0]   prev_q,  prev_d;
   logic [NCH-1:0]   filt_q,  filt_d;
   logic [NCH-1:0]   rise_q,  rise_d;
   logic [NCH-1:0]   fall_q,  fall_d;
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];
   logic [NCH-1:0]   accept;

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= INIT;
         sync2_q <= INIT;
         prev_q  <= INIT;
         filt_q  <= INIT;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         filt_q  <= filt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      sync1_d = sig_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      filt_d  = filt_q;
      rise_d  = '0;
      fall_d  = '0;
      accept  = '0;
      for (int i = 0; i < NCH; i++) begin
         // Any movement between sync2 and prev restarts the stability window;
         // otherwise count up and park at the terminal value.
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] != prev_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end

         // A saturated counter only matters while prev differs from the
         // filtered level, so a held level never re-fires an edge.
         accept[i] = (cnt_q[i] == CNT_MAX) && (prev_q[i] != filt_q[i]);
         if (accept[i]) begin
            filt_d[i] = prev_q[i];
            rise_d[i] = prev_q[i];
            fall_d[i] = ~prev_q[i];
         end
      end
   end

   assign sig_filt = filt_q;
   assign sig_rise = rise_q;
   assign sig_fall = fall_q;
   assign any_rise = |rise_q;

`ifdef DBNC_GLITCH_CNT_EN
   // ------------------------------------------------------------------------
   // Glitch diagnostics: a glitch is sync2/prev disagreeing while a
   // transition is pending (prev != filtered), i.e. the pending change is
   // being abandoned before acceptance.
   // ------------------------------------------------------------------------
   logic [7:0] glitch_q [NCH];
   logic [7:0] glitch_d [NCH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            glitch_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            glitch_q[i] <= glitch_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         glitch_d[i] = glitch_q[i];
         // Clear has priority over a coincident increment.
         if (glitch_clr) begin
            glitch_d[i] = '0;
         end else if ((sync2_q[i] != prev_q[i]) && (prev_q[i] != filt_q[i]) &&
                      (glitch_q[i] != 8'hFF)) begin
            glitch_d[i] = glitch_q[i] + 8'd1;
         end
      end
   end

   always_comb begin
      glitch_cnt = '0;
      for (int i = 0; i < NCH; i++) begin
         glitch_cnt[8*i +: 8] = glitch_q[i];
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dbnc_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbnc_bank
// Description : Directed self-checking bench for dbnc_bank with NCH=4,
//               STBL_CNT=4, INIT=4'b0010. Glitch counter steps are compiled
//               in only when DBNC_GLITCH_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbnc_bank;

   localparam int unsigned    NCH      = 4;
   localparam int unsigned    STBL_CNT = 4;
   localparam logic [NCH-1:0] INIT     = 4'b0010;

   logic            clk;
   logic            rst_n;
   logic [NCH-1:0]  sig_in;
   logic [NCH-1:0]  sig_filt;
   logic [NCH-1:0]  sig_rise;
   logic [NCH-1:0]  sig_fall;
   logic            any_rise;
`ifdef DBNC_GLITCH_CNT_EN
   logic            glitch_clr;
   logic [8*NCH-1:0] glitch_cnt;
`endif

   int total = 0;
   int bad   = 0;

   dbnc_bank #(
      .NCH      (NCH),
      .STBL_CNT (STBL_CNT),
      .INIT     (INIT)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in),
`ifdef DBNC_GLITCH_CNT_EN
      .glitch_clr (glitch_clr),
      .glitch_cnt (glitch_cnt),
`endif
      .sig_filt   (sig_filt),
      .sig_rise   (sig_rise),
      .sig_fall   (sig_fall),
      .any_rise   (any_rise)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Level plus both pulse vectors plus any_rise in one shot.
   task automatic chk_all(input string tag, input logic [3:0] f, input logic [3:0] r,
                          input logic [3:0] fl);
      chk({tag, "_filt"}, 32'(sig_filt), 32'(f));
      chk({tag, "_rise"}, 32'(sig_rise), 32'(r));
      chk({tag, "_fall"}, 32'(sig_fall), 32'(fl));
      chk({tag, "_any"},  32'(any_rise), 32'(|r));
   endtask

   initial begin
      rst_n  = 1'b0;
      sig_in = INIT;
`ifdef DBNC_GLITCH_CNT_EN
      glitch_clr = 1'b0;
`endif

      // ---- reset and idle ----
      tick();
      tick();
      chk_all("reset", 4'b0010, 4'b0000, 4'b0000);
`ifdef DBNC_GLITCH_CNT_EN
      chk("reset_glitch", glitch_cnt, 32'h0);
`endif
      #4 rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk_all("idle", 4'b0010, 4'b0000, 4'b0000);
      end

      // ---- ch1 falls from its INIT level of 1 ----
      sig_in = 4'b0000;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_all("ch1fall_wait", 4'b0010, 4'b0000, 4'b0000);
      end
      tick();                                   // E7
      chk_all("ch1fall_e7", 4'b0000, 4'b0000, 4'b0010);
      tick();
      chk_all("ch1fall_e8", 4'b0000, 4'b0000, 4'b0000);

      // ---- clean rise on ch0 ----
      sig_in = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_all("rise_wait", 4'b0000, 4'b0000, 4'b0000);
      end
      tick();                                   // E7
      chk_all("rise_e7", 4'b0001, 4'b0001, 4'b0000);
      tick();                                   // E8
      chk_all("rise_e8", 4'b0001, 4'b0000, 4'b0000);

      // ---- short glitch on ch1: three synchronised high cycles ----
      sig_in = 4'b0011;
      tick();
      tick();
      tick();
      sig_in = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk_all("glitch_hold", 4'b0001, 4'b0000, 4'b0000);
      end
`ifdef DBNC_GLITCH_CNT_EN
      chk("glitch_ch1", glitch_cnt, 32'h0000_0100);
`endif

      // ---- simultaneous: ch0 falls, ch3 rises ----
      sig_in = 4'b1000;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_all("simul_wait", 4'b0001, 4'b0000, 4'b0000);
      end
      tick();                                   // E7
      chk_all("simul_e7", 4'b1000, 4'b1000, 4'b0001);
      tick();
      chk_all("simul_e8", 4'b1000, 4'b0000, 4'b0000);

`ifdef DBNC_GLITCH_CNT_EN
      // ---- glitch saturation and clear on ch2 ----
      for (int k = 0; k < 10; k++) begin
         sig_in = 4'b1100;
         tick();
         sig_in = 4'b1000;
         tick();
      end
      tick(); tick(); tick(); tick();
      chk("sat_10", glitch_cnt, 32'h000A_0100);
      for (int k = 0; k < 290; k++) begin
         sig_in = 4'b1100;
         tick();
         sig_in = 4'b1000;
         tick();
      end
      tick(); tick(); tick(); tick();
      chk("sat_255", glitch_cnt, 32'h00FF_0100);
      chk("sat_filt", 32'(sig_filt), 32'h8);

      // One more aborted pulse; clear lands on the edge where it would count.
      sig_in = 4'b1100;
      tick();                                   // E1
      sig_in = 4'b1000;
      tick();                                   // E2
      tick();                                   // E3
      glitch_clr = 1'b1;
      tick();                                   // E4: glitch + clear
      glitch_clr = 1'b0;
      chk("clr_wins", glitch_cnt, 32'h0);
      sig_in = 4'b1100;
      tick();
      sig_in = 4'b1000;
      tick(); tick(); tick(); tick();
      chk("after_clr", glitch_cnt, 32'h0001_0000);
`endif

      // ---- reset mid-count on ch0 ----
      sig_in = 4'b1001;
      tick(); tick(); tick(); tick(); tick();   // E5: ch0 counter at 2
      rst_n = 1'b0;
      #1;
      chk_all("midrst_async", 4'b0010, 4'b0000, 4'b0000);
`ifdef DBNC_GLITCH_CNT_EN
      chk("midrst_glitch", glitch_cnt, 32'h0);
`endif
      tick();
      tick();
      #4 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_all("midrst_wait", 4'b0010, 4'b0000, 4'b0000);
      end
      tick();                                   // E7 after release
      chk_all("midrst_e7", 4'b1001, 4'b1001, 4'b0010);
      tick();
      chk_all("midrst_e8", 4'b1001, 4'b0000, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
